pwm_multi: RTL
==============

// Module: pwm_multi
//
// PURPOSE
// Multi-channel, parametrised successor to the single-channel 8-bit PWM.
// CHANNELS outputs share one free-running WIDTH-bit period counter, with a programmable clock prescaler.
// Duty values arrive over a valid/ready handshake into a shadow buffer and are applied only at a period
// boundary, so no glitched periods occur. An optional full-scale mode removes the one-count low dip at max duty.
// Sits between the sample/mixer datapath and the audio output pins.
//
// PARAMETERS
// WIDTH       8  bits per duty value and period counter (period = 2**WIDTH ticks)
// CHANNELS    2  number of independent PWM outputs
// PRESCALE_W  4  width of prescale input
//
// PORTS
// clk           in   1                 system clock, rising edge
// nrst          in   1                 asynchronous active-low reset
// en            in   1                 run enable; 0 = counter/prescaler held at 0, outputs low
// full_mode     in   1                 1 = all-ones duty drives output constantly high
// prescale      in   PRESCALE_W        counter advances once every prescale+1 clocks
// sample        in   CHANNELS*WIDTH    duty values, channel i at [i*WIDTH +: WIDTH]
// sample_valid  in   1                 sample holds a new duty set
// sample_ready  out  1                 shadow buffer empty, can accept
// period_end    out  1                 1-cycle strobe: last tick of current period
// pwm_o         out  CHANNELS          PWM outputs
//
// BEHAVIOUR
// - Reset (async, nrst=0): count=0, prescaler=0, active duty=0 (all ch), shadow empty.
//   Reset outputs: pwm_o=0, period_end=0, sample_ready=1.
// - Tick: tick=en && (pre_cnt==prescale).
//   pre_cnt increments every clk while en; it clears to 0 on tick.
//   If prescale changes mid-count and pre_cnt>prescale, pre_cnt counts up and wraps at 2**PRESCALE_W before ticking.
// - Counter: on tick, count<=count+1, mod 2**WIDTH (2**WIDTH-1 wraps to 0).
// - Handshake: accept when sample_valid && sample_ready.
//   Accept latches all channels into the shadow and sets shadow_full. sample_ready = !shadow_full (combinational from reg).
//   sample must be stable only in the accept cycle. Valid while not ready is held off and no data is lost.
// - Apply: when en=1 and tick && count==2**WIDTH-1, if shadow_full, active<=shadow and shadow_full<=0
//   (same edge as the count wrap). The new duty governs the period starting at count=0.
//   When en=0, a full shadow is applied on the next clk, so a fresh duty holds at enable.
// - Simultaneous accept and apply cannot occur: accept needs shadow empty and apply needs it full.
//   An accept on the wrap edge with an empty shadow takes effect at the following period.
// - period_end = en && tick && count==2**WIDTH-1 (combinational from regs/inputs).
// - pwm_o[i] = en && ((count < duty[i]) || (full_mode && duty[i]=={WIDTH{1'b1}})), combinational from regs.
//   duty=0 gives always low. Max duty with full_mode=0 gives low only at count=max (legacy dip).
// - High time per period = duty*(prescale+1) clocks; period = 2**WIDTH*(prescale+1) clocks.
// - en falling: the next clk edge forces count=0 and pre_cnt=0; pwm_o drops immediately (combinational gate).
//   Active duty and shadow are kept.
// - Reset mid-period: all state clears async. A pending shadow is discarded.
//
// TESTING (WIDTH=8, CHANNELS=2, prescale=0 unless noted)
// 1 Reset: nrst=0 with en=1, valid=1 -> pwm_o=00, period_end=0, sample_ready=1; hold across 2 clocks.
// 2 Basic duty: load ch0=127, ch1=0 while en=0, then set en=1 -> ch0 high for exactly 127 clks, low for 129;
//   ch1 always low; period_end once per 256 clks.
// 3 Full scale: ch0=255. full_mode=0 -> exactly 1 low clk per 256; full_mode=1 -> constantly high.
// 4 Boundary update: running at ch0=64; accept ch0=200 at count=10 -> sample_ready=0 until wrap;
//   remaining period stays 64, next period is 200-high; second valid while full is held until ready.
// 5 Prescale: prescale=3, ch0=2 -> high 8 clks, period 1024 clks, period_end width 1 clk.
// 6 Mid-op: drop en at count=100 -> pwm_o=0, count=0, duty kept; re-enable restarts at count 0.
//   nrst pulse with full shadow -> shadow empty, duty 0.

Source files
------------

// File: rtl/pwm_multi.sv
`default_nettype none
// ============================================================================
// pwm_multi : multi-channel PWM on one shared prescaled period counter, with
//             handshaked duty shadow applied at period boundaries. Rev 1.0
// ============================================================================
module pwm_multi #(
  parameter int WIDTH      = 8,
  parameter int CHANNELS   = 2,
  parameter int PRESCALE_W = 4
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic                      en,
  input  logic                      full_mode,
  input  logic [PRESCALE_W-1:0]     prescale,
  input  logic [CHANNELS*WIDTH-1:0] sample,
  input  logic                      sample_valid,
  output logic                      sample_ready,
  output logic                      period_end,
  output logic [CHANNELS-1:0]       pwm_o
);

  localparam logic [WIDTH-1:0] c_cnt_max = '1;

  logic [PRESCALE_W-1:0]     r_pre_cnt;
  logic [WIDTH-1:0]          r_count;
  logic [CHANNELS*WIDTH-1:0] r_active;
  logic [CHANNELS*WIDTH-1:0] r_shadow;
  logic                      r_shadow_full;

  logic w_tick;
  logic w_wrap;
  logic w_accept;
  logic w_apply;

  // A prescale lowered below the running pre_cnt lets pre_cnt wrap naturally.
  assign w_tick   = en && (r_pre_cnt == prescale);
  assign w_wrap   = w_tick && (r_count == c_cnt_max);
  assign w_accept = sample_valid && !r_shadow_full;
  // While disabled a pending duty is taken at once so it is live at enable.
  assign w_apply  = r_shadow_full && (!en || w_wrap);

  assign sample_ready = !r_shadow_full;
  assign period_end   = w_wrap;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_pre_cnt <= '0;
      r_count   <= '0;
    end else if (!en) begin
      r_pre_cnt <= '0;
      r_count   <= '0;
    end else if (w_tick) begin
      r_pre_cnt <= '0;
      r_count   <= r_count + 1'b1;
    end else begin
      r_pre_cnt <= r_pre_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_active      <= '0;
      r_shadow      <= '0;
      r_shadow_full <= 1'b0;
    end else if (w_apply) begin
      r_active      <= r_shadow;
      r_shadow_full <= 1'b0;
    end else if (w_accept) begin
      r_shadow      <= sample;
      r_shadow_full <= 1'b1;
    end
  end

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
    logic [WIDTH-1:0] w_duty;
    assign w_duty    = r_active[gi*WIDTH +: WIDTH];
    assign pwm_o[gi] = en && ((r_count < w_duty) ||
                              (full_mode && (w_duty == c_cnt_max)));
  end

endmodule
`default_nettype wire
